// File: rtl/dsp_chain_sop2_sched.sv
// Issue controller and credit-protected result FIFO for a 3-stage fp16 sop2 DSP chain.
// Latency: a beat accepted at edge N is written into the FWFT FIFO at edge N+CHAIN_LAT+1.
// Backpressure: in_ready drops once FIFO entries plus in-flight beats reach FIFO_DEPTH; define SCHED_PERF_EN for perf counters.
module dsp_chain_sop2_sched #(
  parameter int          CHAIN_LAT  = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LEN_W      = 8,
  parameter logic [10:0] MODE       = 11'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [191:0]     in_ops,
  output logic [191:0]     dsp_ops,
  output logic [10:0]      dsp_mode_sigs,
  input  logic [31:0]      dsp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             job_done,
  output logic             busy
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + CHAIN_LAT + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE0} state_t;
  state_t state_q, state_d;

  logic [LEN_W-1:0] len_q, beat_cnt_q;
  logic [CHAIN_LAT:0] vld_pipe_q, last_pipe_q;
  logic [32:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fifo_cnt_q;
  logic [CW-1:0]    inflight, occupancy;
  logic             credit_ok, job_acc, issue, beat_last, exit_vld, exit_last, fifo_rd;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= CHAIN_LAT; i++) inflight = inflight + CW'(vld_pipe_q[i]);
  end

  // Every in-flight beat already owns a FIFO slot, so a pipe exit can never find the FIFO full.
  assign occupancy     = CW'(fifo_cnt_q) + inflight;
  assign credit_ok     = occupancy < CW'(FIFO_DEPTH);
  assign job_ready     = (state_q == IDLE) && reset;
  assign in_ready      = (state_q == ISSUE) && credit_ok;
  assign job_acc       = job_valid && job_ready;
  assign issue         = in_valid && in_ready;
  assign beat_last     = (beat_cnt_q + LEN_W'(1)) == len_q;
  assign exit_vld      = vld_pipe_q[CHAIN_LAT];
  assign exit_last     = last_pipe_q[CHAIN_LAT];
  assign fifo_rd       = out_valid && out_ready;
  assign busy          = state_q != IDLE;
  assign dsp_mode_sigs = MODE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (job_valid) state_d = (job_len == '0) ? DONE0 : ISSUE;
      ISSUE:   if (issue && beat_last) state_d = DRAIN;
      DRAIN:   if (exit_vld && exit_last) state_d = IDLE;
      DONE0:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q       <= '0;
      beat_cnt_q  <= '0;
      dsp_ops     <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      job_done    <= 1'b0;
    end else begin
      if (job_acc) begin
        len_q      <= job_len;
        beat_cnt_q <= '0;
      end else if (issue) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end
      if (issue) dsp_ops <= in_ops;
      // Shadow of the chain: one slot per register stage plus the result capture cycle.
      vld_pipe_q  <= {vld_pipe_q[CHAIN_LAT-1:0], issue};
      last_pipe_q <= {last_pipe_q[CHAIN_LAT-1:0], issue && beat_last};
      job_done    <= (job_acc && (job_len == '0)) || (exit_vld && exit_last);
    end
  end

  always_ff @(posedge clk) begin
    if (exit_vld) fifo_mem[wr_ptr_q] <= {exit_last, dsp_result};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (exit_vld) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_rd)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({exit_vld, fifo_rd})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (AW+1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (AW+1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign out_valid = fifo_cnt_q != '0;
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q][31:0] : 32'd0;
  assign out_last  = out_valid ? fifo_mem[rd_ptr_q][32] : 1'b0;

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((state_q == ISSUE) && in_valid && !credit_ok) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_chain_sop2_sched.sv
// Bench for dsp_chain_sop2_sched: directed jobs, a 4-cycle chain model and a result scoreboard.
module tb_dsp_chain_sop2_sched;
  localparam int FIFO_DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, job_valid, job_ready, in_valid, in_ready;
  logic [7:0]   job_len;
  logic [191:0] in_ops, dsp_ops;
  logic [10:0]  dsp_mode_sigs;
  logic [31:0]  dsp_result, out_data;
  logic         out_valid, out_ready, out_last, job_done, busy;
  logic         out_ready_drv, tog_en, tog_q;
`ifdef SCHED_PERF_EN
  logic [31:0]  perf_issue_cnt, perf_stall_cnt;
`endif

  assign out_ready = tog_en ? tog_q : out_ready_drv;

  dsp_chain_sop2_sched dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops), .dsp_ops(dsp_ops),
    .dsp_mode_sigs(dsp_mode_sigs), .dsp_result(dsp_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .job_done(job_done),
    .busy(busy)
`ifdef SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fold(input logic [191:0] o);
    fold = o[191:160] ^ o[159:128] ^ o[127:96] ^ o[95:64] ^ o[63:32] ^ o[31:0];
  endfunction

  function automatic logic [191:0] mk_ops(input int job, input int b);
    mk_ops = {32'hC0DE_0000 | {16'd0, 8'(job), 8'(b)}, 32'h1111_1111, 32'h2222_2222,
              32'h4444_4444, 32'h8888_8888, 32'(b * 3 + 1)};
  endfunction

  // Chain model: dsp_result reflects dsp_ops four register stages later.
  logic [31:0] chain_s [4];
  always @(posedge clk) begin
    chain_s[0] <= fold(dsp_ops);
    for (int i = 1; i < 4; i++) chain_s[i] <= chain_s[i-1];
  end
  assign dsp_result = chain_s[3];

  always @(posedge clk) begin
    #1 tog_q = ~tog_q;
  end

  // Scoreboard: every accepted beat owes exactly one result, in order, last flag on the job's final beat.
  logic [32:0] sb_q [$];
  logic [32:0] held_word, exp_w;
  logic        held = 1'b0;
  bit          issuing = 1'b0;
  int          cur_len = 0, cur_beat = 0;
  int          n_rx = 0, n_last_rx = 0, n_done = 0;

  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
      issuing = 1'b0;
      held = 1'b0;
    end else begin
      check("in_ready_credit", in_ready, issuing && (sb_q.size() < FIFO_DEPTH));
      if (held) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", {out_last, out_data}, held_word);
      end
      held = out_valid && !out_ready;
      held_word = {out_last, out_data};
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", {out_last, out_data}, 33'h0_DEAD_BEEF);
        end else begin
          exp_w = sb_q.pop_front();
          check("out_data", out_data, exp_w[31:0]);
          check("out_last", out_last, exp_w[32]);
          n_rx++;
          if (out_last) n_last_rx++;
        end
      end
      if (job_done) n_done++;
      if (job_valid && job_ready) begin
        cur_len = int'(job_len);
        cur_beat = 0;
        issuing = (job_len != 0);
      end
      if (in_valid && in_ready) begin
        cur_beat++;
        sb_q.push_back({cur_beat == cur_len, fold(in_ops)});
        if (cur_beat == cur_len) issuing = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    bit ok = 1'b0;
    job_valid = 1'b1;
    job_len = 8'(len);
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = job_ready;
      tick();
    end
    job_valid = 1'b0;
    check("job_accept", ok, 1);
  endtask

  int beat_id;
  task automatic send_beats(input int n, input int budget, input int job, output int acc, output int stalls);
    bit hs;
    acc = 0;
    stalls = 0;
    in_valid = 1'b1;
    in_ops = mk_ops(job, beat_id);
    for (int c = 0; c < budget && acc < n; c++) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      if (hs) begin
        acc++;
        beat_id++;
        in_ops = mk_ops(job, beat_id);
      end else begin
        stalls++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      tick();
      ok = !busy && !out_valid;
    end
    check("drain_timeout", ok, 1);
    check("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int acc, st, rx0, d0, l0;
  logic [191:0] ops1;
  bit ok1;

  initial begin
    reset = 1'b0; job_valid = 1'b0; job_len = '0; in_valid = 1'b0; in_ops = '0;
    out_ready_drv = 1'b1; tog_en = 1'b0; tog_q = 1'b0;
    repeat (3) tick();
    check("rst_job_ready", job_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_job_done", job_done, 0);
    check("rst_busy", busy, 0);
    check("rst_dsp_ops", dsp_ops[63:0] | dsp_ops[127:64] | dsp_ops[191:128], 0);
    check("mode_sigs", dsp_mode_sigs, 0);
    reset = 1'b1;
    #1;
    check("idle_job_ready", job_ready, 1);
    tick();

    // len=1: literal result and exact N+5 timing
    ops1 = {32'h0000_00FF, 128'd0, 32'h1234_5678};
    check("fold_literal", fold(ops1), 32'h1234_5687);
    start_job(1);
    in_valid = 1'b1; in_ops = ops1; ok1 = 1'b0;
    for (int c = 0; c < 50 && !ok1; c++) begin
      @(negedge clk);
      ok1 = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check("len1_accept", ok1, 1);
    check("dsp_ops_lo", dsp_ops[31:0], 32'h1234_5678);
    check("dsp_ops_hi", dsp_ops[191:160], 32'h0000_00FF);
    repeat (4) tick();
    check("len1_not_yet", out_valid, 0);
    check("dsp_ops_hold", dsp_ops[31:0], 32'h1234_5678);
    tick();
    check("len1_valid", out_valid, 1);
    check("len1_last", out_last, 1);
    check("len1_done", job_done, 1);
    check("len1_data", out_data, 32'h1234_5687);
    check("len1_idle", busy, 0);
    tick();
    check("len1_done_pulse", job_done, 0);
    check("len1_popped", out_valid, 0);
    wait_idle();

    // len=20 at full rate
    rx0 = n_rx; d0 = n_done; l0 = n_last_rx; beat_id = 0;
    start_job(20);
    send_beats(20, 100, 2, acc, st);
    check("full_rate_acc", acc, 20);
    check("full_rate_stalls", st, 0);
    wait_idle();
    check("full_rate_rx", n_rx - rx0, 20);
    check("full_rate_last", n_last_rx - l0, 1);
    check("full_rate_done", n_done - d0, 1);

    // len=20 against a blocked consumer
    rx0 = n_rx; d0 = n_done; l0 = n_last_rx; beat_id = 0;
    out_ready_drv = 1'b0;
    start_job(20);
    send_beats(20, 30, 3, acc, st);
    check("credit_limit_acc", acc, 8);
    check("credit_in_ready", in_ready, 0);
    check("credit_fifo_valid", out_valid, 1);
    out_ready_drv = 1'b1;
    send_beats(12, 200, 3, acc, st);
    check("credit_rest_acc", acc, 12);
    wait_idle();
    check("credit_rx", n_rx - rx0, 20);
    check("credit_last", n_last_rx - l0, 1);
    check("credit_done", n_done - d0, 1);

    // len=0
    rx0 = n_rx; d0 = n_done;
    start_job(0);
    check("len0_done", job_done, 1);
    check("len0_busy", busy, 1);
    tick();
    check("len0_done_off", job_done, 0);
    check("len0_idle", busy, 0);
    check("len0_ready", job_ready, 1);
    check("len0_no_write", out_valid, 0);
    tick();
    check("len0_pulses", n_done - d0, 1);
    check("len0_rx", n_rx - rx0, 0);

    // back-to-back len=3, len=2 with toggling out_ready
    rx0 = n_rx; d0 = n_done; l0 = n_last_rx;
    tog_en = 1'b1;
    beat_id = 0;
    start_job(3);
    send_beats(3, 100, 6, acc, st);
    check("b2b_acc3", acc, 3);
    beat_id = 0;
    start_job(2);
    send_beats(2, 100, 7, acc, st);
    check("b2b_acc2", acc, 2);
    wait_idle();
    tog_en = 1'b0;
    check("b2b_rx", n_rx - rx0, 5);
    check("b2b_last", n_last_rx - l0, 2);
    check("b2b_done", n_done - d0, 2);

    // reset in DRAIN with three beats in flight
    rx0 = n_rx;
    beat_id = 0;
    start_job(3);
    send_beats(3, 100, 8, acc, st);
    check("mid_acc", acc, 3);
    check("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_job_done", job_done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_job_ready", job_ready, 0);
    check("mid_rst_dsp_ops", dsp_ops[63:0] | dsp_ops[127:64] | dsp_ops[191:128], 0);
`ifdef SCHED_PERF_EN
    check("mid_rst_perf_issue", perf_issue_cnt, 0);
    check("mid_rst_perf_stall", perf_stall_cnt, 0);
`endif
    repeat (2) tick();
    reset = 1'b1;
    repeat (12) tick();
    check("mid_rst_no_results", n_rx - rx0, 0);
    check("mid_rst_fifo_empty", out_valid, 0);
    check("mid_rst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
